// File: rtl/spi_axi_pkg.sv
// spi_axi_pkg: shared burst/response encodings and state enums for the SPI-side AXI slave plug
package spi_axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {TOP_IDLE, TOP_AW, TOP_AR, TOP_WRITE, TOP_READ} top_state_t;
  typedef enum logic [1:0] {WR_DATA, WR_MEM, WR_RESP} wr_state_t;
  typedef enum logic {RD_MEM, RD_DATA} rd_state_t;
endpackage

// File: rtl/spi_axi_addr_gen.sv
// spi_axi_addr_gen: next beat address for FIXED/INCR bursts and the unsupported-burst flag
//   addr/size/burst : current beat descriptor
//   next_addr       : address of the following beat (32-bit wrap-around)
//   err             : WRAP burst or size wider than 64 bits
module spi_axi_addr_gen
  import spi_axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        err
);
  logic [31:0] step;
  assign step      = 32'd1 << size;
  assign next_addr = burst == BURST_FIXED ? addr : (addr & ~(step - 32'd1)) + step;
  assign err       = burst == BURST_WRAP || size > 3'd3;
endmodule

// File: rtl/spi_axi_slave_plug.sv
// spi_axi_slave_plug: AXI4 slave turning 64-bit bursts into sequential 32-bit request/grant word accesses
//   axi_aclk/axi_areset : clock, asynchronous active-high reset
//   axi_slave_aw/w/b    : write burst address, data and response channels
//   axi_slave_ar/r      : read burst address and data channels
//   mem_*               : single-outstanding word port (req held until gnt, rvalid returns read data)
module spi_axi_slave_plug
  import spi_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  input  logic                        axi_slave_aw_valid,
  output logic                        axi_slave_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
  input  logic [7:0]                  axi_slave_aw_len,
  input  logic [2:0]                  axi_slave_aw_size,
  input  logic [1:0]                  axi_slave_aw_burst,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
  input  logic [2:0]                  axi_slave_aw_prot,
  input  logic [3:0]                  axi_slave_aw_region,
  input  logic                        axi_slave_aw_lock,
  input  logic [3:0]                  axi_slave_aw_cache,
  input  logic [3:0]                  axi_slave_aw_qos,
  input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
  input  logic                        axi_slave_ar_valid,
  output logic                        axi_slave_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
  input  logic [7:0]                  axi_slave_ar_len,
  input  logic [2:0]                  axi_slave_ar_size,
  input  logic [1:0]                  axi_slave_ar_burst,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
  input  logic [2:0]                  axi_slave_ar_prot,
  input  logic [3:0]                  axi_slave_ar_region,
  input  logic                        axi_slave_ar_lock,
  input  logic [3:0]                  axi_slave_ar_cache,
  input  logic [3:0]                  axi_slave_ar_qos,
  input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
  input  logic                        axi_slave_w_valid,
  output logic                        axi_slave_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
  input  logic                        axi_slave_w_last,
  input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
  output logic                        axi_slave_b_valid,
  input  logic                        axi_slave_b_ready,
  output logic [1:0]                  axi_slave_b_resp,
  output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
  output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
  output logic                        axi_slave_r_valid,
  input  logic                        axi_slave_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
  output logic [1:0]                  axi_slave_r_resp,
  output logic                        axi_slave_r_last,
  output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
  output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user,
  output logic                        mem_req,
  input  logic                        mem_gnt,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [3:0]                  mem_be,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata
);
  top_state_t top_q, top_d;
  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;
  logic prio_rd_q;
  logic [31:0] addr_q, next_addr;
  logic [7:0] len_q, beat_cnt_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [63:0] wdata_q, rdata_q;
  logic [7:0] strb_q;
  logic [1:0] done_q, need, pend;
  logic wait_q, rd_half_q, resp_err_q;
  logic err, wr_act, rd_act, half, last_beat, w_hs, r_hs;
  logic unused_inputs;
  spi_axi_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .err       (err)
  );
  assign unused_inputs = ^{axi_slave_aw_prot, axi_slave_aw_region, axi_slave_aw_lock, axi_slave_aw_cache,
                           axi_slave_aw_qos, axi_slave_aw_user, axi_slave_ar_prot, axi_slave_ar_region,
                           axi_slave_ar_lock, axi_slave_ar_cache, axi_slave_ar_qos, axi_slave_ar_user,
                           axi_slave_w_user};
  assign wr_act    = top_q == TOP_WRITE;
  assign rd_act    = top_q == TOP_READ;
  assign last_beat = beat_cnt_q == len_q;
  // Halves this beat must touch; done_q marks the ones already granted.
  assign need = {2{!err}} & (wr_act ? {|strb_q[7:4], |strb_q[3:0]} :
                             size_q == 3'd3 ? 2'b11 : addr_q[2] ? 2'b10 : 2'b01);
  assign pend = need & ~done_q;
  assign half = !pend[0];
  // Every AXI output is decoded from registered state only.
  assign axi_slave_aw_ready = top_q == TOP_AW;
  assign axi_slave_ar_ready = top_q == TOP_AR;
  assign axi_slave_w_ready  = wr_act && wr_q == WR_DATA;
  assign axi_slave_b_valid  = wr_act && wr_q == WR_RESP;
  assign axi_slave_b_resp   = axi_slave_b_valid && (resp_err_q || err) ? RESP_SLVERR : RESP_OKAY;
  assign axi_slave_b_id     = id_q;
  assign axi_slave_b_user   = '0;
  assign axi_slave_r_valid  = rd_act && rd_q == RD_DATA;
  assign axi_slave_r_data   = rdata_q;
  assign axi_slave_r_resp   = axi_slave_r_valid && err ? RESP_SLVERR : RESP_OKAY;
  assign axi_slave_r_last   = axi_slave_r_valid && last_beat;
  assign axi_slave_r_id     = id_q;
  assign axi_slave_r_user   = '0;
  assign w_hs = axi_slave_w_valid && axi_slave_w_ready;
  assign r_hs = axi_slave_r_valid && axi_slave_r_ready;
  assign mem_req   = |pend && (wr_act && wr_q == WR_MEM || rd_act && rd_q == RD_MEM && !wait_q);
  assign mem_we    = mem_req && wr_act;
  assign mem_addr  = mem_req ? {addr_q[31:3], half, 2'b00} : 32'h0;
  assign mem_be    = !mem_req ? 4'h0 : !wr_act ? 4'hF : half ? strb_q[7:4] : strb_q[3:0];
  assign mem_wdata = mem_we ? (half ? wdata_q[63:32] : wdata_q[31:0]) : 32'h0;
  always_comb begin
    top_d = top_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    case (top_q)
      TOP_IDLE: top_d = axi_slave_aw_valid && !(axi_slave_ar_valid && prio_rd_q) ? TOP_AW :
                        axi_slave_ar_valid ? TOP_AR : TOP_IDLE;
      TOP_AW: begin
        top_d = TOP_WRITE;
        wr_d  = WR_DATA;
      end
      TOP_AR: begin
        top_d = TOP_READ;
        rd_d  = RD_MEM;
      end
      TOP_WRITE:
        case (wr_q)
          WR_DATA: wr_d = axi_slave_w_valid ? WR_MEM : WR_DATA;
          WR_MEM:  wr_d = |pend ? WR_MEM : last_beat ? WR_RESP : WR_DATA;
          default: top_d = axi_slave_b_ready ? TOP_IDLE : TOP_WRITE;
        endcase
      TOP_READ:
        if (rd_q == RD_MEM) begin
          rd_d = !(|pend) && !wait_q ? RD_DATA : RD_MEM;
        end else if (axi_slave_r_ready) begin
          top_d = last_beat ? TOP_IDLE : TOP_READ;
          rd_d  = last_beat ? RD_DATA : RD_MEM;
        end
      default: top_d = TOP_IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      top_q      <= TOP_IDLE;
      wr_q       <= WR_DATA;
      rd_q       <= RD_MEM;
      prio_rd_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      wait_q     <= 1'b0;
      rd_half_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      top_q <= top_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      if (top_q == TOP_AW || top_q == TOP_AR) begin
        prio_rd_q  <= top_q == TOP_AW;
        addr_q     <= top_q == TOP_AW ? 32'(axi_slave_aw_addr) : 32'(axi_slave_ar_addr);
        len_q      <= top_q == TOP_AW ? axi_slave_aw_len : axi_slave_ar_len;
        size_q     <= top_q == TOP_AW ? axi_slave_aw_size : axi_slave_ar_size;
        burst_q    <= top_q == TOP_AW ? axi_slave_aw_burst : axi_slave_ar_burst;
        id_q       <= top_q == TOP_AW ? axi_slave_aw_id : axi_slave_ar_id;
        beat_cnt_q <= '0;
        done_q     <= '0;
        rdata_q    <= '0;
        wait_q     <= 1'b0;
        resp_err_q <= 1'b0;
      end
      if (w_hs) begin
        wdata_q <= axi_slave_w_data;
        strb_q  <= axi_slave_w_strb;
        done_q  <= '0;
        // A misplaced w_last flags the response but never cuts the burst short.
        if (axi_slave_w_last != last_beat) resp_err_q <= 1'b1;
      end
      if (mem_req && mem_gnt) begin
        done_q[half] <= 1'b1;
        wait_q       <= rd_act;
        rd_half_q    <= half;
      end
      if (wait_q && mem_rvalid) begin
        wait_q <= 1'b0;
        if (rd_half_q) rdata_q[63:32] <= mem_rdata;
        else rdata_q[31:0] <= mem_rdata;
      end
      if (r_hs) begin
        done_q  <= '0;
        rdata_q <= '0;
      end
      if (!last_beat && (r_hs || wr_act && wr_q == WR_MEM && !(|pend))) begin
        addr_q     <= next_addr;
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
    end
  end
endmodule
